// File: rtl/cpu10_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu10_pkg
//  Description : Shared definitions for the 10-bit CPU datapath: datapath and
//                register-address widths, the hard-wired zero register, and
//                the pipeline entry carried through the MEM and WB registers.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu10_pkg;

  // Datapath width and register address width (8 registers, r0 reads as 0).
  localparam int DATA_W = 10;
  localparam int ADDR_W = 3;

  localparam logic [ADDR_W-1:0] REG_ZERO = 3'd0;

  // One result in flight between EX and the RegFile write port.
  typedef struct packed {
    logic              valid;
    logic              is_load;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } pipe_entry_t;

  // True when a valid entry targets a non-zero source register.
  function automatic logic entry_hits(input pipe_entry_t entry,
                                      input logic [ADDR_W-1:0] addr);
    return entry.valid && (entry.dest == addr) && (addr != REG_ZERO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_writeback_fwd_mux.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_mux
//  Description : Priority operand select for one register-file read port.
//                Order: r0 -> zero, younger non-load MEM result, WB result,
//                then the RegFile read data.
//  Ports       : addr      in   source register address
//                mem_entry in   MEM pipeline register contents
//                wb_entry  in   WB pipeline register contents
//                rf_data   in   RegFile read data for this port
//                opnd      out  forwarded operand
//  Revision    : 1.0  initial release
// ============================================================================
module fwd_mux
  import cpu10_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  input  pipe_entry_t       mem_entry,
  input  pipe_entry_t       wb_entry,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] opnd
);

  always_comb begin
    opnd = rf_data;
    if (addr == REG_ZERO) begin
      opnd = '0;
    end else if (entry_hits(mem_entry, addr) && !mem_entry.is_load) begin
      // A load in MEM has no data yet; the stall covers that case and the
      // value is picked up from WB one cycle later.
      opnd = mem_entry.data;
    end else if (entry_hits(wb_entry, addr)) begin
      // Also covers the cycle in which the RegFile is being written and read
      // at the same address.
      opnd = wb_entry.data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_writeback
//  Description : Write-side companion of the 8x10-bit register file. Carries
//                EX results through MEM and WB pipeline registers, drives the
//                RegFile write port, forwards operands to both read ports and
//                raises a one-cycle load-use stall.
//  Parameters  : CNT_W         width of the saturating retired-write counter
//                (DATA_W / ADDR_W come from cpu10_pkg)
//  Ports       : clk, reset                 clock, synchronous active-high reset
//                ex_valid/dest/data/is_load EX stage result
//                mem_rdata                  data memory read data (load in MEM)
//                flush                      kill EX input and MEM entry
//                read_addr_1/2, rf_data_1/2 ID read addresses and RegFile data
//                rf_write_en/dest/data      RegFile write port
//                opnd_1/2                   forwarded operands
//                stall                      load-use hazard
//                wb_count                   committed register writes
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_writeback
  import cpu10_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_dest,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              ex_is_load,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              flush,
  input  logic [ADDR_W-1:0] read_addr_1,
  input  logic [ADDR_W-1:0] read_addr_2,
  input  logic [DATA_W-1:0] rf_data_1,
  input  logic [DATA_W-1:0] rf_data_2,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_dest,
  output logic [DATA_W-1:0] rf_write_data,
  output logic [DATA_W-1:0] opnd_1,
  output logic [DATA_W-1:0] opnd_2,
  output logic              stall,
  output logic [CNT_W-1:0]  wb_count
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  pipe_entry_t      r_mem;
  pipe_entry_t      r_wb;
  pipe_entry_t      w_mem_next;
  pipe_entry_t      w_wb_next;
  logic             w_stall;
  logic             w_capture;
  logic [CNT_W-1:0] r_wb_count;

  // Load-use hazard: the loaded value is not available until the load
  // reaches WB, so a dependent instruction in ID must wait one cycle.
  assign w_stall = r_mem.valid && r_mem.is_load &&
                   (entry_hits(r_mem, read_addr_1) || entry_hits(r_mem, read_addr_2));

  // r0 results are dropped here so they are never written or forwarded.
  assign w_capture = ex_valid && !w_stall && !flush && (ex_dest != REG_ZERO);

  always_comb begin
    w_mem_next = '0;
    if (w_capture) begin
      w_mem_next.valid   = 1'b1;
      w_mem_next.is_load = ex_is_load;
      w_mem_next.dest    = ex_dest;
      w_mem_next.data    = ex_is_load ? '0 : ex_data;
    end
  end

  // The load's data is picked up from memory as it leaves MEM.
  always_comb begin
    w_wb_next = '0;
    if (!flush) begin
      w_wb_next = r_mem;
      if (r_mem.is_load) begin
        w_wb_next.data = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem      <= '0;
      r_wb       <= '0;
      r_wb_count <= '0;
    end else begin
      r_mem <= w_mem_next;
      r_wb  <= w_wb_next;
      if (r_wb.valid && (r_wb_count != '1)) begin
        r_wb_count <= r_wb_count + C_CNT_ONE;
      end
    end
  end

  fwd_mux u_fwd_1 (
    .addr      (read_addr_1),
    .mem_entry (r_mem),
    .wb_entry  (r_wb),
    .rf_data   (rf_data_1),
    .opnd      (opnd_1)
  );

  fwd_mux u_fwd_2 (
    .addr      (read_addr_2),
    .mem_entry (r_mem),
    .wb_entry  (r_wb),
    .rf_data   (rf_data_2),
    .opnd      (opnd_2)
  );

  assign rf_write_en   = r_wb.valid;
  assign rf_write_dest = r_wb.dest;
  assign rf_write_data = r_wb.data;
  assign stall         = w_stall;
  assign wb_count      = r_wb_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_writeback
//  Description : Directed self-checking bench for regfile_writeback.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_writeback;

  logic       clk = 1'b0;
  logic       reset;
  logic       ex_valid;
  logic [2:0] ex_dest;
  logic [9:0] ex_data;
  logic       ex_is_load;
  logic [9:0] mem_rdata;
  logic       flush;
  logic [2:0] read_addr_1;
  logic [2:0] read_addr_2;
  logic [9:0] rf_data_1;
  logic [9:0] rf_data_2;
  logic       rf_write_en;
  logic [2:0] rf_write_dest;
  logic [9:0] rf_write_data;
  logic [9:0] opnd_1;
  logic [9:0] opnd_2;
  logic       stall;
  logic [3:0] wb_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Narrow counter so saturation is reachable in a short run.
  regfile_writeback #(.CNT_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .ex_valid      (ex_valid),
    .ex_dest       (ex_dest),
    .ex_data       (ex_data),
    .ex_is_load    (ex_is_load),
    .mem_rdata     (mem_rdata),
    .flush         (flush),
    .read_addr_1   (read_addr_1),
    .read_addr_2   (read_addr_2),
    .rf_data_1     (rf_data_1),
    .rf_data_2     (rf_data_2),
    .rf_write_en   (rf_write_en),
    .rf_write_dest (rf_write_dest),
    .rf_write_data (rf_write_data),
    .opnd_1        (opnd_1),
    .opnd_2        (opnd_2),
    .stall         (stall),
    .wb_count      (wb_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b1;
    ex_valid    = 1'b0;
    ex_dest     = 3'd0;
    ex_data     = 10'h000;
    ex_is_load  = 1'b0;
    mem_rdata   = 10'h000;
    flush       = 1'b0;
    read_addr_1 = 3'd1;
    read_addr_2 = 3'd2;
    rf_data_1   = 10'h2A1;
    rf_data_2   = 10'h2A2;
    tick;
    tick;

    // Reset state
    chk("rst_wen",   32'(rf_write_en),   32'd0);
    chk("rst_dest",  32'(rf_write_dest), 32'd0);
    chk("rst_data",  32'(rf_write_data), 32'd0);
    chk("rst_cnt",   32'(wb_count),      32'd0);
    chk("rst_stall", 32'(stall),         32'd0);
    chk("rst_opnd1", 32'(opnd_1),        32'h2A1);
    chk("rst_opnd2", 32'(opnd_2),        32'h2A2);

    // 1: r3 = 155 written exactly two edges after capture
    reset = 1'b0; read_addr_1 = 3'd0; read_addr_2 = 3'd0;
    ex_valid = 1'b1; ex_dest = 3'd3; ex_data = 10'h155;
    tick;
    ex_valid = 1'b0; #1;
    chk("t1_wen_edge1", 32'(rf_write_en), 32'd0);
    tick;
    chk("t1_wen",  32'(rf_write_en),   32'd1);
    chk("t1_dest", 32'(rf_write_dest), 32'd3);
    chk("t1_data", 32'(rf_write_data), 32'h155);
    tick;
    chk("t1_wen_edge3", 32'(rf_write_en), 32'd0);
    chk("t1_cnt",       32'(wb_count),    32'd1);

    // 2: r2 = 0AA forwarded from MEM, then from WB
    ex_valid = 1'b1; ex_dest = 3'd2; ex_data = 10'h0AA;
    tick;
    ex_valid = 1'b0; read_addr_1 = 3'd2; #1;
    chk("t2_fwd_mem", 32'(opnd_1), 32'h0AA);
    tick;
    chk("t2_fwd_wb", 32'(opnd_1),      32'h0AA);
    chk("t2_wen",    32'(rf_write_en), 32'd1);
    tick;
    chk("t2_rf",  32'(opnd_1),   32'h2A1);
    chk("t2_cnt", 32'(wb_count), 32'd2);

    // 3: load r4 -> one stall cycle; EX input during the stall is dropped
    read_addr_1 = 3'd0;
    ex_valid = 1'b1; ex_dest = 3'd4; ex_data = 10'h011; ex_is_load = 1'b1;
    tick;
    ex_is_load = 1'b0; ex_dest = 3'd7; ex_data = 10'h077;
    read_addr_2 = 3'd4; mem_rdata = 10'h3FF; #1;
    chk("t3_stall", 32'(stall), 32'd1);
    tick;
    ex_valid = 1'b0; #1;
    chk("t3_stall_end", 32'(stall),         32'd0);
    chk("t3_opnd2",     32'(opnd_2),        32'h3FF);
    chk("t3_wen",       32'(rf_write_en),   32'd1);
    chk("t3_dest",      32'(rf_write_dest), 32'd4);
    chk("t3_data",      32'(rf_write_data), 32'h3FF);
    tick;
    chk("t3_dropped", 32'(rf_write_en), 32'd0);
    chk("t3_cnt",     32'(wb_count),    32'd3);

    // 4: r0 is never written
    read_addr_2 = 3'd0;
    ex_valid = 1'b1; ex_dest = 3'd0; ex_data = 10'h123;
    tick;
    ex_valid = 1'b0; #1;
    chk("t4_opnd1", 32'(opnd_1), 32'd0);
    tick;
    chk("t4_wen", 32'(rf_write_en), 32'd0);
    chk("t4_cnt", 32'(wb_count),    32'd3);

    // 5: back-to-back r5=1, r5=2; youngest forwarded, writes in order
    ex_valid = 1'b1; ex_dest = 3'd5; ex_data = 10'h001;
    tick;
    ex_data = 10'h002;
    tick;
    ex_valid = 1'b0; read_addr_1 = 3'd5; #1;
    chk("t5_fwd_young", 32'(opnd_1),        32'h002);
    chk("t5_wen1",      32'(rf_write_en),   32'd1);
    chk("t5_data1",     32'(rf_write_data), 32'h001);
    tick;
    chk("t5_data2", 32'(rf_write_data), 32'h002);
    chk("t5_opnd",  32'(opnd_1),        32'h002);
    tick;
    chk("t5_cnt", 32'(wb_count), 32'd5);

    // 6a: flush kills a MEM load to r6; stall still reported that cycle
    read_addr_1 = 3'd0;
    ex_valid = 1'b1; ex_dest = 3'd6; ex_data = 10'h000; ex_is_load = 1'b1;
    tick;
    ex_valid = 1'b0; ex_is_load = 1'b0;
    flush = 1'b1; read_addr_2 = 3'd6; mem_rdata = 10'h155; #1;
    chk("t6_stall_flush", 32'(stall), 32'd1);
    tick;
    flush = 1'b0; read_addr_2 = 3'd0; #1;
    chk("t6_flush_wen", 32'(rf_write_en), 32'd0);

    // 6b: reset with r7 in WB and r1 in MEM discards both
    ex_valid = 1'b1; ex_dest = 3'd7; ex_data = 10'h0F0;
    tick;
    ex_dest = 3'd1; ex_data = 10'h0C3;
    tick;
    ex_valid = 1'b0; #1;
    chk("t6_wb_before_rst", 32'(rf_write_en), 32'd1);
    reset = 1'b1;
    tick;
    chk("t6_rst_wen",  32'(rf_write_en),   32'd0);
    chk("t6_rst_dest", 32'(rf_write_dest), 32'd0);
    chk("t6_rst_data", 32'(rf_write_data), 32'd0);
    chk("t6_rst_cnt",  32'(wb_count),      32'd0);
    reset = 1'b0; read_addr_1 = 3'd1; read_addr_2 = 3'd7; #1;
    chk("t6_opnd1_rf", 32'(opnd_1), 32'h2A1);
    chk("t6_opnd2_rf", 32'(opnd_2), 32'h2A2);
    tick;
    chk("t6_post_wen", 32'(rf_write_en), 32'd0);

    // 7: 17 writes saturate the 4-bit counter at 15
    read_addr_1 = 3'd0; read_addr_2 = 3'd0;
    for (int i = 0; i < 17; i++) begin
      ex_valid = 1'b1; ex_dest = 3'd1; ex_data = 10'(i);
      tick;
    end
    ex_valid = 1'b0;
    tick;
    tick;
    chk("t7_cnt_sat", 32'(wb_count),    32'hF);
    chk("t7_wen",     32'(rf_write_en), 32'd0);
    tick;
    chk("t7_cnt_hold", 32'(wb_count), 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
